orv64_mul_ctrl: RTL and testbench



---
 rtl/orv64_mul_ctrl.sv | 178 +++++++++++++++++
 tb/tb_orv64_mul_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/orv64_mul_ctrl.sv
// Issue/return controller in front of the sequential orv64_mul multiplier.
// Owns the operand/result flops, a one-entry result cache, kill handling and a BUSY watchdog.

package orv64_mul_pkg;
    localparam int unsigned ORV64_N_CYCLE_INT_MUL = 13;

    typedef enum logic [2:0] {
        MulTypeL,
        MulTypeHss,
        MulTypeHsu,
        MulTypeHuu,
        MulTypeW
    } orv64_mul_type_t;
endpackage

module orv64_mul_ctrl
    import orv64_mul_pkg::*;
#(
    parameter int unsigned N_CYC       = ORV64_N_CYCLE_INT_MUL,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [63:0]     req_rs1,
    input  logic [63:0]     req_rs2,
    input  orv64_mul_type_t req_mul_type,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [63:0]     resp_data,
    output logic            mul_start_pulse,
    output logic [63:0]     mul_rs1,
    output logic [63:0]     mul_rs2,
    output orv64_mul_type_t mul_type,
    input  logic [63:0]     mul_rdh,
    input  logic [63:0]     mul_rdl,
    input  logic            mul_complete,
    output logic            err_timeout
);

    if (N_CYC < 2 || TIMEOUT_CYC <= N_CYC) begin : g_cfg_check
        $error("orv64_mul_ctrl: TIMEOUT_CYC must exceed N_CYC and N_CYC must be >= 2");
    end

    localparam int unsigned       CntW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0]   CntMax = CntW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StDone} state_t;
    typedef enum logic [1:0] {ClsSs, ClsSu, ClsUu} cls_t;

    function automatic cls_t cls_of(input orv64_mul_type_t t);
        case (t)
            MulTypeHsu: return ClsSu;
            MulTypeHuu: return ClsUu;
            default:    return ClsSs;
        endcase
    endfunction

    state_t          state;
    logic [CntW-1:0] to_cnt;

    logic            cache_valid;
    logic [63:0]     cache_rs1;
    logic [63:0]     cache_rs2;
    cls_t            cache_cls;
    logic [63:0]     cache_rdh;
    logic [63:0]     cache_rdl;

    logic            cache_hit;
    logic [63:0]     hit_data;
    logic [63:0]     miss_data;

    assign req_ready = (state == StIdle);

    assign cache_hit = cache_valid && (req_rs1 == cache_rs1) && (req_rs2 == cache_rs2) &&
                       (cls_of(req_mul_type) == cache_cls);

    // The cache always holds a 64-bit-op result, so W must re-extend bit 31 on a hit.
    always_comb begin
        hit_data = cache_rdh;
        if (req_mul_type == MulTypeL) begin
            hit_data = cache_rdl;
        end else if (req_mul_type == MulTypeW) begin
            hit_data = {{32{cache_rdl[31]}}, cache_rdl[31:0]};
        end
    end

    always_comb begin
        miss_data = mul_rdh;
        if (mul_type == MulTypeL || mul_type == MulTypeW) begin
            miss_data = mul_rdl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StIdle;
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            mul_start_pulse <= 1'b0;
            mul_rs1         <= '0;
            mul_rs2         <= '0;
            mul_type        <= MulTypeL;
            err_timeout     <= 1'b0;
            to_cnt          <= '0;
            cache_valid     <= 1'b0;
            cache_rs1       <= '0;
            cache_rs2       <= '0;
            cache_cls       <= ClsSs;
            cache_rdh       <= '0;
            cache_rdl       <= '0;
        end else begin
            mul_start_pulse <= 1'b0;
            if (kill && state != StIdle) begin
                state      <= StIdle;
                resp_valid <= 1'b0;
                to_cnt     <= '0;
            end else begin
                case (state)
                    StIdle: begin
                        if (req_valid) begin
                            mul_rs1  <= req_rs1;
                            mul_rs2  <= req_rs2;
                            mul_type <= req_mul_type;
                            if (cache_hit) begin
                                state      <= StDone;
                                resp_valid <= 1'b1;
                                resp_data  <= hit_data;
                            end else begin
                                state           <= StLaunch;
                                mul_start_pulse <= 1'b1;
                            end
                        end
                    end
                    StLaunch: begin
                        state <= StBusy;
                    end
                    StBusy: begin
                        if (mul_complete) begin
                            state      <= StDone;
                            resp_valid <= 1'b1;
                            resp_data  <= miss_data;
                            to_cnt     <= '0;
                            if (mul_type != MulTypeW) begin
                                cache_valid <= 1'b1;
                                cache_rs1   <= mul_rs1;
                                cache_rs2   <= mul_rs2;
                                cache_cls   <= cls_of(mul_type);
                                cache_rdh   <= mul_rdh;
                                cache_rdl   <= mul_rdl;
                            end
                        end else begin
                            if (to_cnt != CntMax) begin
                                to_cnt <= to_cnt + 1'b1;
                            end
                            // This BUSY cycle is number to_cnt+1; flag once it reaches the limit.
                            if (to_cnt >= CntMax - 1'b1) begin
                                err_timeout <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        if (resp_ready) begin
                            state      <= StIdle;
                            resp_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_orv64_mul_ctrl.sv
// Bench for orv64_mul_ctrl: behavioural multiplier model plus ISA-level expected results,
// with directed scenarios followed by a randomized run against a simple cache model.

module tb_orv64_mul_ctrl;
    import orv64_mul_pkg::*;

    localparam int unsigned N_CYC       = 13;
    localparam int unsigned TIMEOUT_CYC = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [63:0]     req_rs1 = '0;
    logic [63:0]     req_rs2 = '0;
    orv64_mul_type_t req_mul_type = MulTypeL;
    logic            kill = 1'b0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [63:0]     resp_data;
    logic            mul_start_pulse;
    logic [63:0]     mul_rs1;
    logic [63:0]     mul_rs2;
    orv64_mul_type_t mul_type;
    logic [63:0]     mul_rdh;
    logic [63:0]     mul_rdl;
    logic            mul_complete;
    logic            err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Multiplier model state
    logic            mul_en = 1'b1;
    logic            stray_complete = 1'b0;
    int              m_cnt = 0;
    logic            m_complete = 1'b0;
    orv64_mul_type_t m_t = MulTypeL;
    logic [63:0]     m_a = '0;
    logic [63:0]     m_b = '0;
    logic [63:0]     m_rdh = '0;
    logic [63:0]     m_rdl = '0;

    // Reference cache model: last completed non-W operation
    bit              cv = 1'b0;
    logic [63:0]     c_a = '0;
    logic [63:0]     c_b = '0;
    int              c_cls = 0;

    orv64_mul_ctrl #(
        .N_CYC       (N_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rs1         (req_rs1),
        .req_rs2         (req_rs2),
        .req_mul_type    (req_mul_type),
        .kill            (kill),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .mul_start_pulse (mul_start_pulse),
        .mul_rs1         (mul_rs1),
        .mul_rs2         (mul_rs2),
        .mul_type        (mul_type),
        .mul_rdh         (mul_rdh),
        .mul_rdl         (mul_rdl),
        .mul_complete    (mul_complete),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension result semantics on full 128-bit products
    function automatic logic [63:0] isa(input orv64_mul_type_t t, input logic [63:0] a,
                                        input logic [63:0] b);
        logic [127:0] sa, sb, ua, ub, p;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'd0, a};
        ub = {64'd0, b};
        case (t)
            MulTypeHss: begin p = sa * sb; return p[127:64]; end
            MulTypeHsu: begin p = sa * ub; return p[127:64]; end
            MulTypeHuu: begin p = ua * ub; return p[127:64]; end
            MulTypeW:   begin p = ua * ub; return {{32{p[31]}}, p[31:0]}; end
            default:    begin p = sa * sb; return p[63:0]; end
        endcase
    endfunction

    function automatic int cls_num(input orv64_mul_type_t t);
        if (t == MulTypeHsu) return 1;
        if (t == MulTypeHuu) return 2;
        return 0;
    endfunction

    // Complete is raised N_CYC-1 cycles after the start cycle; a new start restarts it.
    always @(posedge clk) begin
        m_complete <= 1'b0;
        if (mul_start_pulse) begin
            m_cnt <= int'(N_CYC) - 2;
            m_t   <= mul_type;
            m_a   <= mul_rs1;
            m_b   <= mul_rs2;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_complete <= 1'b1;
                m_rdl <= (m_t == MulTypeW) ? isa(MulTypeW, m_a, m_b) : isa(MulTypeL, m_a, m_b);
                m_rdh <= (m_t == MulTypeL || m_t == MulTypeW) ? isa(MulTypeHss, m_a, m_b)
                                                              : isa(m_t, m_a, m_b);
            end
        end
    end

    assign mul_complete = (m_complete & mul_en) | stray_complete;
    assign mul_rdh = stray_complete ? 64'hDEAD_BEEF_0BAD_F00D : m_rdh;
    assign mul_rdl = stray_complete ? 64'hBADC_0FFE_E0DD_F00D : m_rdl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, check latency/start pulse/result, hold DONE for 'hold' cycles, then retire.
    task automatic run_op(input orv64_mul_type_t t, input logic [63:0] a, input logic [63:0] b,
                          input int hold, input bit kill_idle, input string tag);
        bit          hit;
        int          lat;
        int          starts;
        int          start_at;
        logic [63:0] exp;
        hit = cv && (a == c_a) && (b == c_b) && (cls_num(t) == c_cls);
        exp = isa(t, a, b);
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_rs1      = a;
        req_rs2      = b;
        req_mul_type = t;
        kill         = kill_idle;
        step();
        req_valid = 1'b0;
        kill      = 1'b0;
        req_rs1   = {$urandom, $urandom};
        req_rs2   = {$urandom, $urandom};
        chk({tag, "_op_rs1"}, mul_rs1, a);
        chk({tag, "_op_type"}, 64'(mul_type), 64'(t));
        lat      = 1;
        starts   = 0;
        start_at = -1;
        while (!resp_valid && lat < 200) begin
            if (mul_start_pulse) begin
                starts++;
                start_at = lat;
            end
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), hit ? 64'd1 : 64'(N_CYC + 1));
        chk({tag, "_starts"}, 64'(starts), hit ? 64'd0 : 64'd1);
        if (!hit) chk({tag, "_start_cycle"}, 64'(start_at), 64'd1);
        chk({tag, "_data"}, resp_data, exp);
        for (int i = 0; i < hold; i++) begin
            req_valid      = 1'b1;
            req_rs1        = ~a;
            stray_complete = (i == 0);
            step();
            stray_complete = 1'b0;
            chk({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
            chk({tag, "_hold_data"}, resp_data, exp);
            chk({tag, "_hold_noaccept"}, 64'(req_ready), 64'd0);
        end
        if (hold > 0) chk({tag, "_hold_rs1"}, mul_rs1, a);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, "_retired"}, 64'(resp_valid), 64'd0);
        chk({tag, "_idle"}, 64'(req_ready), 64'd1);
        if (!hit && t != MulTypeW) begin
            cv    = 1'b1;
            c_a   = a;
            c_b   = b;
            c_cls = cls_num(t);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        orv64_mul_type_t rt;
        logic [63:0]     ra, rb, pa, pb;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_start", 64'(mul_start_pulse), 64'd0);
        chk("rst_rs1", mul_rs1, 64'd0);
        chk("rst_rs2", mul_rs2, 64'd0);
        chk("rst_type", 64'(mul_type), 64'(MulTypeL));
        chk("rst_err", 64'(err_timeout), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic MUL, then class mismatch miss, then hit paths
        run_op(MulTypeL, 64'd3, 64'd5, 0, 1'b0, "mul_3x5");
        run_op(MulTypeHuu, '1, '1, 0, 1'b0, "mulhu_ones");
        run_op(MulTypeL, '1, '1, 0, 1'b0, "mul_ones_miss");
        run_op(MulTypeHss, -64'sd2, 64'd3, 0, 1'b0, "mulh_m2x3");
        run_op(MulTypeL, -64'sd2, 64'd3, 0, 1'b0, "mul_m2x3_hit");
        run_op(MulTypeL, 64'h8000_0000, 64'd1, 0, 1'b0, "mul_8000");
        run_op(MulTypeW, 64'h8000_0000, 64'd1, 0, 1'b0, "mulw_hit");
        run_op(MulTypeL, 64'h8000_0000, 64'd1, 0, 1'b0, "mul_after_w_hit");
        run_op(MulTypeW, 64'h1_7FFF_FFFF, 64'd3, 0, 1'b0, "mulw_miss");
        run_op(MulTypeL, 64'h8000_0000, 64'd1, 0, 1'b0, "w_miss_keeps_cache");

        // Kill in BUSY, new op accepted on the following cycle
        req_valid    = 1'b1;
        req_rs1      = 64'h1234_5678;
        req_rs2      = 64'h10;
        req_mul_type = MulTypeL;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_busy_idle", 64'(req_ready), 64'd1);
        chk("kill_busy_noresp", 64'(resp_valid), 64'd0);
        run_op(MulTypeL, 64'd7, 64'd6, 0, 1'b0, "mul_7x6_after_kill");

        // Kill in LAUNCH: pulse still issued, its later complete lands in IDLE
        req_valid    = 1'b1;
        req_rs1      = 64'hAAAA;
        req_rs2      = 64'h5555;
        req_mul_type = MulTypeHsu;
        step();
        req_valid = 1'b0;
        chk("kill_launch_pulse", 64'(mul_start_pulse), 64'd1);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_launch_idle", 64'(req_ready), 64'd1);
        chk("kill_launch_pulse_off", 64'(mul_start_pulse), 64'd0);
        repeat (N_CYC + 2) step();
        chk("stale_complete_noresp", 64'(resp_valid), 64'd0);
        chk("stale_complete_idle", 64'(req_ready), 64'd1);
        run_op(MulTypeL, 64'd7, 64'd6, 0, 1'b0, "cache_survives_kill");
        run_op(MulTypeHsu, 64'hAAAA, 64'h5555, 0, 1'b1, "kill_in_idle_accept");

        // Backpressure with stray completes during DONE
        run_op(MulTypeHss, 64'hF000_0000_0000_0001, 64'h7, 10, 1'b0, "backpressure");

        // Randomized operations with occasional operand reuse to exercise the cache
        pa = 64'd0;
        pb = 64'd0;
        for (int i = 0; i < 30; i++) begin
            rt = orv64_mul_type_t'($urandom_range(0, 4));
            if (i > 0 && $urandom_range(0, 2) == 0) begin
                ra = pa;
                rb = pb;
            end else begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
            end
            run_op(rt, ra, rb, int'($urandom_range(0, 2)), 1'b0, "rand");
            pa = ra;
            pb = rb;
        end

        // Timeout with the multiplier never completing
        mul_en       = 1'b0;
        req_valid    = 1'b1;
        req_rs1      = 64'h5;
        req_rs2      = 64'h9;
        req_mul_type = MulTypeL;
        step();
        req_valid = 1'b0;
        repeat (TIMEOUT_CYC) step();
        chk("timeout_not_yet", 64'(err_timeout), 64'd0);
        step();
        chk("timeout_set", 64'(err_timeout), 64'd1);
        repeat (20) step();
        chk("timeout_sticky", 64'(err_timeout), 64'd1);
        chk("timeout_still_busy", 64'(req_ready), 64'd0);
        chk("timeout_noresp", 64'(resp_valid), 64'd0);

        // Asynchronous reset mid-operation clears everything, including the cache
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_err", 64'(err_timeout), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        chk("midrst_rs1", mul_rs1, 64'd0);
        chk("midrst_type", 64'(mul_type), 64'(MulTypeL));
        step();
        rst_n  = 1'b1;
        cv     = 1'b0;
        mul_en = 1'b1;
        step();
        run_op(MulTypeL, pa, pb, 0, 1'b0, "post_reset_miss");
        run_op(MulTypeHss, pa, pb, 0, 1'b0, "post_reset_hit");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
